matrix_load_sequencer: RTL and testbench

Upstream feeder for the 5-to-18 element-select decoder in the matrix multiplication accelerator. Accepts a stream of operand elements over a valid/ready handshake. Assigns each element a sequential slot index 0..17: slots 0..8 hold A in row-major order, slots 9..17 hold B in row-major order. Drives the registered index, write strobe and data that the decoder and the 18 operand registers consume. Holds a "matrices loaded" flag until the compute stage acknowledges it.

---
 rtl/matrix_load_sequencer_pkg.sv | 18 +
 rtl/matrix_load_sequencer.sv | 88 ++++++++
 tb/tb_matrix_load_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_load_sequencer_pkg.sv
// Shared definitions for the operand load path of the 3x3 matrix multiply accelerator.
// Slot layout: A occupies 0..8 and B occupies 9..17, both row-major.
package matrix_load_sequencer_pkg;

   localparam int MLS_NUM_ELEMS = 18;
   localparam int MLS_DATA_W    = 8;
   localparam int MLS_ADDR_W    = 5;

   localparam int A_BASE_IDX = 0;
   localparam int B_BASE_IDX = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } state_t;

endpackage

// File: rtl/matrix_load_sequencer.sv
// Feeds the element-select decoder: numbers each accepted element with its slot index
// and presents a registered write strobe, index and data one cycle after the accept.
module matrix_load_sequencer
   import matrix_load_sequencer_pkg::*;
#(
   parameter int NUM_ELEMS = MLS_NUM_ELEMS,
   parameter int DATA_W    = MLS_DATA_W,
   parameter int ADDR_W    = MLS_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              loaded,
   input  logic              loaded_ack
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ELEMS - 1);

   state_t            state;
   logic [ADDR_W-1:0] count;
   logic              accept;

   // abort must kill the handshake in the same cycle, so in_ready cannot be a flop
   assign in_ready = (state == ST_LOAD) && !abort;
   assign accept   = in_valid && in_ready;
   assign busy     = (state == ST_LOAD);
   assign loaded   = (state == ST_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         count   <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         wr_en <= accept;
         if (accept) begin
            wr_addr <= count;
            wr_data <= in_data;
         end

         if (abort) begin
            state <= ST_IDLE;
            count <= '0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (start) begin
                     state <= ST_LOAD;
                     count <= '0;
                  end
               end
               ST_LOAD: begin
                  if (accept) begin
                     // count is parked at 0 rather than stepping past the last slot
                     if (count == LAST_IDX) begin
                        state <= ST_FULL;
                        count <= '0;
                     end else begin
                        count <= count + 1'b1;
                     end
                  end
               end
               ST_FULL: begin
                  if (loaded_ack) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  count <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Self-checking bench for matrix_load_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_matrix_load_sequencer;
   import matrix_load_sequencer_pkg::*;

   localparam int N  = MLS_NUM_ELEMS;
   localparam int DW = MLS_DATA_W;
   localparam int AW = MLS_ADDR_W;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [AW-1:0] wr_addr;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          loaded;
   logic          loaded_ack;

   int checks = 0;
   int errors = 0;

   matrix_load_sequencer #(
      .NUM_ELEMS(N),
      .DATA_W   (DW),
      .ADDR_W   (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .wr_addr   (wr_addr),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .busy      (busy),
      .loaded    (loaded),
      .loaded_ack(loaded_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: "loading" / "full" phases, number of elements taken so far,
   // and the write that the decoder must see after each edge.
   bit            m_loading;
   bit            m_full;
   int            m_taken;
   bit            e_wr_en;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_loading = 0;
         m_full    = 0;
         m_taken   = 0;
         e_wr_en   = 0;
         e_addr    = '0;
         e_data    = '0;
      end else begin
         bit took;
         took    = m_loading && !abort && in_valid;
         e_wr_en = took;
         if (took) begin
            e_addr = AW'(m_taken);
            e_data = in_data;
         end
         if (abort) begin
            m_loading = 0;
            m_full    = 0;
            m_taken   = 0;
         end else if (m_loading) begin
            if (took) begin
               m_taken++;
               if (m_taken == N) begin
                  m_loading = 0;
                  m_full    = 1;
                  m_taken   = 0;
               end
            end
         end else if (m_full) begin
            if (loaded_ack) m_full = 0;
         end else if (start) begin
            m_loading = 1;
            m_taken   = 0;
         end
      end
   end

   // Inputs change on the falling edge; compare shortly after, when both the new
   // inputs and the registered outputs of the last rising edge are stable.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         check("in_ready", in_ready, m_loading && !abort);
         check("busy",     busy,     m_loading);
         check("loaded",   loaded,   m_full);
         check("wr_en",    wr_en,    e_wr_en);
         check("wr_addr",  wr_addr,  e_addr);
         check("wr_data",  wr_data,  e_data);
         if (wr_en) check("wr_addr_range", (wr_addr < AW'(N)), 1'b1);
      end
   end

   task automatic drive(input bit s, input bit a, input bit v, input logic [DW-1:0] d, input bit k);
      @(negedge clk);
      start      = s;
      abort      = a;
      in_valid   = v;
      in_data    = d;
      loaded_ack = k;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_wr_addr"},  wr_addr,  0);
      check({tag, "_wr_en"},    wr_en,    0);
      check({tag, "_wr_data"},  wr_data,  0);
      check({tag, "_busy"},     busy,     0);
      check({tag, "_loaded"},   loaded,   0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] gap_pat;
      int         sent;
      int         cyc;
      bit         v;
      bit         pulse;

      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      loaded_ack = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // in_valid without start is ignored
      repeat (3) drive(0, 0, 1, 8'hAA, 0);

      // Full load, back-to-back elements 0x10..0x21
      drive(1, 0, 0, '0, 0);
      after_edge();
      check("start_busy", busy, 1);
      for (int i = 0; i < N; i++) begin
         drive(0, 0, 1, 8'(8'h10 + i), 0);
         after_edge();
         check("full_wr_en",   wr_en,   1);
         check("full_wr_addr", wr_addr, i);
         check("full_wr_data", wr_data, 8'h10 + i);
         if (i == B_BASE_IDX) check("b_base_slot", wr_addr, 9);
         if (i == N - 1) begin
            check("last_loaded",   loaded,   1);
            check("last_busy",     busy,     0);
            check("last_in_ready", in_ready, 0);
         end else begin
            check("mid_loaded", loaded, 0);
         end
      end

      // Handoff: loaded held until acknowledged, then an immediate restart
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 8'h55, 0);
         after_edge();
         check("hold_loaded",   loaded,   1);
         check("hold_in_ready", in_ready, 0);
      end
      drive(0, 0, 0, '0, 1);
      after_edge();
      check("ack_loaded", loaded, 0);
      drive(1, 0, 0, '0, 0);
      after_edge();
      check("restart_busy",     busy,     1);
      check("restart_in_ready", in_ready, 1);

      // Load with gaps 1,0,0,1 and ignored start/ack pulse at count 4
      gap_pat = 4'b1001;
      sent    = 0;
      cyc     = 0;
      while (sent < N) begin
         v     = (cyc < 4) ? gap_pat[cyc] : 1'b1;
         pulse = v && (sent == 4);
         drive(pulse, 0, v, 8'(8'h40 + sent), pulse);
         if (pulse) begin
            after_edge();
            check("ignored_addr",   wr_addr, 4);
            check("ignored_loaded", loaded,  0);
            check("ignored_busy",   busy,    1);
         end
         if (v) sent++;
         cyc++;
      end
      drive(0, 0, 0, '0, 1);
      drive(0, 0, 0, '0, 0);

      // Abort at count 7 with in_valid high
      drive(1, 0, 0, '0, 0);
      for (int i = 0; i < 7; i++) drive(0, 0, 1, 8'(8'h60 + i), 0);
      drive(0, 1, 1, 8'hEE, 0);
      #1;
      check("abort_in_ready", in_ready, 0);
      check("abort_prev_write", wr_addr, 6);
      after_edge();
      check("abort_wr_en", wr_en, 0);
      check("abort_busy",  busy,  0);
      drive(1, 0, 0, '0, 0);
      drive(0, 0, 1, 8'h80, 0);
      after_edge();
      check("reabort_addr", wr_addr, 0);
      check("reabort_data", wr_data, 8'h80);
      for (int i = 1; i < 5; i++) drive(0, 0, 1, 8'(8'h80 + i), 0);

      // Asynchronous reset mid-load at count 5, away from any clock edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) drive(0, 0, 1, 8'h77, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
               8'($urandom), ($urandom % 4) == 0);
      end
      drive(0, 0, 0, '0, 0);
      @(negedge clk);
      #2;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
